// File: rtl/ad7946_ctrl.sv
// AD7946 sequencer: wake, quiet/convert, then a 16-pulse read of the previous conversion.
// Frame = CS_HIGH_CYCLES high + 34*CLK_DIV low; no backpressure, result is a one-clk strobe.
module ad7946_ctrl #(
  parameter int CLK_DIV        = 2,
  parameter int CS_HIGH_CYCLES = 8,
  parameter int WAKE_CYCLES    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        alt_en,
  input  logic        ch_fixed,
  output logic        pden,
  output logic        chsel,
  output logic        cs_n,
  output logic        sclk,
  input  logic        sdo,
  output logic        dout_valid,
  output logic [11:0] dout_data,
  output logic [1:0]  dout_tag,
  output logic        busy
);

  localparam int WAKE_N = (WAKE_CYCLES < 1) ? 1 : WAKE_CYCLES;
  localparam int MAX_A  = (CLK_DIV > CS_HIGH_CYCLES) ? CLK_DIV : CS_HIGH_CYCLES;
  localparam int MAX_C  = (MAX_A > WAKE_N) ? MAX_A : WAKE_N;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_N - 1);
  localparam logic [CW-1:0] CSH_LAST  = CW'(CS_HIGH_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAKE, S_QUIET, S_SETUP, S_SHIFT, S_TAIL
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [3:0]     r_bcnt;
  logic [12:0]    r_sh;
  logic           r_prime;
  logic           r_pden;
  logic           r_chsel;
  logic           r_cs_n;
  logic           r_sclk;
  logic           r_dout_valid;
  logic [11:0]    r_dout_data;
  logic [1:0]     r_dout_tag;
  logic           r_busy;

  assign pden       = r_pden;
  assign chsel      = r_chsel;
  assign cs_n       = r_cs_n;
  assign sclk       = r_sclk;
  assign dout_valid = r_dout_valid;
  assign dout_data  = r_dout_data;
  assign dout_tag   = r_dout_tag;
  assign busy       = r_busy;

  // r_sh keeps samples s2..s14 only: s1 falls off the top and s15/s16 are the unused LSBs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bcnt       <= '0;
      r_sh         <= '0;
      r_prime      <= 1'b0;
      r_pden       <= 1'b1;
      r_chsel      <= 1'b0;
      r_cs_n       <= 1'b1;
      r_sclk       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_dout_data  <= '0;
      r_dout_tag   <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state <= S_WAKE;
            r_pden  <= 1'b0;
            r_busy  <= 1'b1;
            r_prime <= 1'b1;
            r_cnt   <= '0;
          end
        end
        S_WAKE: begin
          if (!enable) begin
            r_state <= S_IDLE;
            r_pden  <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else if (r_cnt == WAKE_LAST) begin
            r_state <= S_QUIET;
            r_cnt   <= '0;
            r_chsel <= alt_en ? 1'b0 : ch_fixed;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_QUIET: begin
          if (!enable) begin
            r_state <= S_IDLE;
            r_pden  <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else if (r_cnt == CSH_LAST) begin
            r_state <= S_SETUP;
            r_cs_n  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SETUP: begin
          if (r_cnt == DIV_LAST) begin
            r_state <= S_SHIFT;
            r_sclk  <= 1'b1;
            r_cnt   <= '0;
            r_bcnt  <= '0;
            r_sh    <= {r_sh[11:0], sdo};
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          if (r_cnt == DIV_LAST) begin
            r_cnt <= '0;
            if (r_sclk) begin
              r_sclk <= 1'b0;
            end else if (r_bcnt == 4'd15) begin
              r_state <= S_TAIL;
            end else begin
              r_sclk <= 1'b1;
              r_bcnt <= r_bcnt + 1'b1;
              if (r_bcnt <= 4'd12) r_sh <= {r_sh[11:0], sdo};
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_TAIL: begin
          if (r_cnt == DIV_LAST) begin
            r_cs_n  <= 1'b1;
            r_cnt   <= '0;
            r_prime <= 1'b0;
            if (!r_prime) begin
              r_dout_valid <= 1'b1;
              r_dout_tag   <= {1'b0, r_sh[12]};
              r_dout_data  <= r_sh[11:0];
            end
            if (enable) begin
              r_state <= S_QUIET;
              r_chsel <= alt_en ? ~r_chsel : ch_fixed;
            end else begin
              r_state <= S_IDLE;
              r_pden  <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ad7946_ctrl.sv
// Directed bench for ad7946_ctrl: instance 0 uses defaults, instance 1 the minimum timing.
module tb_ad7946_ctrl;

  logic        clk = 1'b0;
  logic [1:0]  rst_n, enable, alt_en, ch_fixed;
  logic [1:0]  sdo = 2'b00;
  wire  [1:0]  pden, chsel, cs_n, sclk, dv, busy;
  logic [11:0] dd [2];
  logic [1:0]  dt [2];

  always #5 clk = ~clk;

  ad7946_ctrl #(.CLK_DIV(2), .CS_HIGH_CYCLES(8), .WAKE_CYCLES(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n[0]), .enable(enable[0]), .alt_en(alt_en[0]), .ch_fixed(ch_fixed[0]),
    .pden(pden[0]), .chsel(chsel[0]), .cs_n(cs_n[0]), .sclk(sclk[0]), .sdo(sdo[0]),
    .dout_valid(dv[0]), .dout_data(dd[0]), .dout_tag(dt[0]), .busy(busy[0]));

  ad7946_ctrl #(.CLK_DIV(1), .CS_HIGH_CYCLES(1), .WAKE_CYCLES(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n[1]), .enable(enable[1]), .alt_en(alt_en[1]), .ch_fixed(ch_fixed[1]),
    .pden(pden[1]), .chsel(chsel[1]), .cs_n(cs_n[1]), .sclk(sclk[1]), .sdo(sdo[1]),
    .dout_valid(dv[1]), .dout_data(dd[1]), .dout_tag(dt[1]), .busy(busy[1]));

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ADC word served in a given frame (frame numbers start at 1 after reset of the bench)
  function automatic logic [15:0] adc_word(input int k, input int idx);
    if (k == 0) return 16'h1234;
    case (idx)
      2:       return 16'h3FFC;
      3:       return 16'h0000;
      default: return 16'h1234;
    endcase
  endfunction

  int          cyc = 0;
  int          n_fall [2], n_rise [2], n_strobe [2], n_wake [2], n_moved [2];
  int          t_fall [2], t_rise [2], t_wake [2];
  int          lo_cnt [2], lo_len [2], hi_len [2], rises [2], last_rises [2], bi [2];
  logic [11:0] st_dat [2];
  logic [1:0]  st_tag [2];
  logic [7:0]  ch_seq [2];
  logic [15:0] w_cur  [2];
  logic [1:0]  fr_ch = 2'b00;
  logic [1:0]  cs_p = 2'b11, sclk_p = 2'b00, pden_p = 2'b11;

  initial begin
    for (int k = 0; k < 2; k++) begin
      n_fall[k] = 0; n_rise[k] = 0; n_strobe[k] = 0; n_wake[k] = 0; n_moved[k] = 0;
      t_fall[k] = 0; t_rise[k] = 0; t_wake[k] = 0; lo_cnt[k] = 0; lo_len[k] = 0;
      hi_len[k] = 0; rises[k] = 0; last_rises[k] = 0; bi[k] = 0;
      st_dat[k] = '0; st_tag[k] = '0; ch_seq[k] = '0; w_cur[k] = '0;
    end
  end

  // Monitor plus ADC model: sdo moves after cs_n fall and after each sclk fall.
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (pden_p[k] && !pden[k]) begin
        n_wake[k]++;
        t_wake[k] = cyc;
      end
      if (cs_p[k] && !cs_n[k]) begin
        n_fall[k]++;
        t_fall[k] = cyc;
        hi_len[k] = cyc - t_rise[k];
        rises[k]  = 0;
        lo_cnt[k] = 0;
        fr_ch[k]  = chsel[k];
        ch_seq[k] = {ch_seq[k][6:0], chsel[k]};
        w_cur[k]  = adc_word(k, n_fall[k]);
        bi[k]     = 15;
        sdo[k]    = w_cur[k][15];
      end
      if (!cs_n[k]) lo_cnt[k]++;
      if (!cs_p[k] && cs_n[k]) begin
        n_rise[k]++;
        t_rise[k]     = cyc;
        lo_len[k]     = lo_cnt[k];
        last_rises[k] = rises[k];
      end
      if (!cs_n[k] && chsel[k] !== fr_ch[k]) n_moved[k]++;
      if (sclk[k] && !sclk_p[k]) rises[k]++;
      if (!sclk[k] && sclk_p[k] && !cs_n[k] && bi[k] > 0) begin
        bi[k]--;
        sdo[k] = w_cur[k][bi[k]];
      end
      if (dv[k]) begin
        n_strobe[k]++;
        st_dat[k] = dd[k];
        st_tag[k] = dt[k];
      end
    end
    cs_p   = cs_n;
    sclk_p = sclk;
    pden_p = pden;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rise(input int k, input int target);
    int n = 0;
    while (n_rise[k] < target && n < 5000) begin tick(); n++; end
    if (n_rise[k] < target) check_eq("timeout_cs_rise", n_rise[k], target);
  endtask

  task automatic wait_fall(input int k, input int target);
    int n = 0;
    while (n_fall[k] < target && n < 5000) begin tick(); n++; end
    if (n_fall[k] < target) check_eq("timeout_cs_fall", n_fall[k], target);
  endtask

  task automatic wait_sclk(input int k, input int target);
    int n = 0;
    while (rises[k] < target && n < 500) begin tick(); n++; end
    if (rises[k] < target) check_eq("timeout_sclk", rises[k], target);
  endtask

  int bs, br, bm, bw, bf, t_rel;

  initial begin
    rst_n = 2'b00; enable = 2'b00; alt_en = 2'b00; ch_fixed = 2'b00;
    repeat (3) tick();
    check_eq("rst_outs_a", {pden[0], cs_n[0], sclk[0], chsel[0], dv[0], busy[0]}, 6'b110000);
    check_eq("rst_word_a", {dt[0], dd[0]}, 0);
    check_eq("rst_outs_b", {pden[1], cs_n[1], sclk[1], chsel[1], dv[1], busy[1]}, 6'b110000);
    check_eq("rst_word_b", {dt[1], dd[1]}, 0);
    rst_n = 2'b11;
    tick();
    check_eq("idle_after_rst", {pden[0], busy[0]}, 2'b10);

    // Basic frame, word 0x1234
    enable[0] = 1'b1;
    wait_rise(0, 1);
    check_eq("prime_no_strobe", n_strobe[0], 0);
    check_eq("wake_to_cs_fall", t_fall[0] - t_wake[0], 24);
    wait_rise(0, 2);
    check_eq("dv_at_cs_rise", dv[0], 1);
    check_eq("strobe_count", n_strobe[0], 1);
    check_eq("data_0x1234", st_dat[0], 12'h48D);
    check_eq("tag_0x1234", st_tag[0], 2'b00);
    check_eq("cs_low_len", lo_len[0], 68);
    check_eq("cs_high_len", hi_len[0], 8);
    check_eq("sclk_rises", last_rises[0], 16);
    tick();
    check_eq("dv_one_clk", dv[0], 0);
    check_eq("data_hold", dd[0], 12'h48D);

    // Enable drop in QUIET: idle next clk, no further cs_n fall
    enable[0] = 1'b0;
    bf = n_fall[0];
    tick();
    check_eq("quiet_drop_idle", {pden[0], busy[0]}, 2'b10);
    repeat (20) tick();
    check_eq("quiet_drop_nofall", n_fall[0], bf);

    // Alternation over 5 frames
    alt_en[0] = 1'b1;
    br = n_rise[0]; bs = n_strobe[0]; bm = n_moved[0];
    enable[0] = 1'b1;
    wait_rise(0, br + 5);
    check_eq("alt_chsel_seq", ch_seq[0][4:0], 5'b01010);
    check_eq("alt_chsel_stable", n_moved[0] - bm, 0);
    check_eq("alt_strobes", n_strobe[0] - bs, 4);

    // Enable removed at 5th sclk pulse
    wait_fall(0, n_fall[0] + 1);
    bs = n_strobe[0]; br = n_rise[0];
    wait_sclk(0, 5);
    enable[0] = 1'b0;
    wait_rise(0, br + 1);
    check_eq("drop_rises", last_rises[0], 16);
    check_eq("drop_strobe", n_strobe[0] - bs, 1);
    tick();
    check_eq("drop_idle", {pden[0], busy[0]}, 2'b10);

    // Reset at 8th sclk pulse
    alt_en[0] = 1'b0;
    enable[0] = 1'b1;
    wait_fall(0, n_fall[0] + 1);
    wait_sclk(0, 8);
    bs = n_strobe[0];
    rst_n[0] = 1'b0;
    #1;
    check_eq("rst_mid_outs", {cs_n[0], sclk[0], dv[0]}, 3'b100);
    tick();
    rst_n[0] = 1'b1;
    t_rel = cyc;
    br = n_rise[0];
    wait_fall(0, n_fall[0] + 1);
    check_eq("rst_wake_gap", (t_fall[0] - t_rel) >= 24, 1);
    wait_rise(0, br + 1);
    check_eq("rst_prime", n_strobe[0] - bs, 0);

    // Enable 1->0->1 with one idle cycle
    enable[0] = 1'b0;
    tick();
    check_eq("toggle_idle", pden[0], 1);
    enable[0] = 1'b1;
    bw = n_wake[0]; bs = n_strobe[0]; br = n_rise[0];
    wait_rise(0, br + 1);
    check_eq("toggle_rewake", n_wake[0] - bw, 1);
    check_eq("toggle_prime", n_strobe[0] - bs, 0);
    wait_rise(0, br + 2);
    check_eq("toggle_strobe", n_strobe[0] - bs, 1);
    enable[0] = 1'b0;

    // Minimum timing instance: 0xFFF then 0x000
    enable[1] = 1'b1;
    wait_rise(1, 2);
    check_eq("b_data_fff", st_dat[1], 12'hFFF);
    check_eq("b_cs_low_len", lo_len[1], 34);
    wait_rise(1, 3);
    check_eq("b_data_000", st_dat[1], 12'h000);
    check_eq("b_cs_high_len", hi_len[1], 1);
    check_eq("b_strobes", n_strobe[1], 2);
    check_eq("b_sclk_rises", last_rises[1], 16);
    enable[1] = 1'b0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
